// File: rtl/mem_block_xfer.sv
// mem_block_xfer: Avalon-MM block-transfer engine.
// The CPU programs SRC/DST/LEN/MODE/FILL through a 16-word CSR slave window,
// then a start write launches a copy (read+write per word) or a fill
// (write-only) of LEN words through the master port.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   slave_*               CSR window (address = word index, zero-wait reads,
//                         accesses other than status reads stall while busy)
//   master_*              SDRAM master (one outstanding read at a time)
//
// CSR map: 0 CTRL/STATUS {done,busy}, 1 SRC, 2 DST, 3 LEN, 4 MODE, 5 FILL.
module mem_block_xfer #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned STRIDE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          slave_waitrequest,
  input  logic [3:0]    slave_address,
  input  logic          slave_read,
  output logic [DW-1:0] slave_readdata,
  input  logic          slave_write,
  input  logic [DW-1:0] slave_writedata,
  input  logic          master_waitrequest,
  output logic [AW-1:0] master_address,
  output logic          master_read,
  input  logic [DW-1:0] master_readdata,
  input  logic          master_readdatavalid,
  output logic          master_write,
  output logic [DW-1:0] master_writedata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } state_e;

  localparam logic [AW-1:0] STEP = AW'(STRIDE);

  state_e           state_q, state_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic [AW-1:0]    wsrc_q, wsrc_d;
  logic [AW-1:0]    wdst_q, wdst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             wmode_q, wmode_d;
  logic [DW-1:0]    data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             csr_wr;
  logic             start;

  // Status reads (address 0) are always serviced; everything else waits
  // until busy falls, which also holds off a start issued while busy.
  always_comb begin
    slave_waitrequest = busy_q &&
                        (slave_write || (slave_read && (slave_address != 4'd0)));
    csr_wr = slave_write && !slave_waitrequest;
    start  = csr_wr && (slave_address == 4'd0) && slave_writedata[0];
  end

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = DW'({done_q, busy_q});
        4'd1:    slave_readdata = DW'(src_q);
        4'd2:    slave_readdata = DW'(dst_q);
        4'd3:    slave_readdata = DW'(len_q);
        4'd4:    slave_readdata = DW'(mode_q);
        4'd5:    slave_readdata = fill_q;
        default: slave_readdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    dst_d            = dst_q;
    len_d            = len_q;
    mode_d           = mode_q;
    fill_d           = fill_q;
    wsrc_d           = wsrc_q;
    wdst_d           = wdst_q;
    rem_d            = rem_q;
    wmode_d          = wmode_q;
    data_d           = data_q;
    busy_d           = busy_q;
    done_d           = done_q;
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;

    if (csr_wr) begin
      case (slave_address)
        4'd1:    src_d  = AW'(slave_writedata);
        4'd2:    dst_d  = AW'(slave_writedata);
        4'd3:    len_d  = LEN_W'(slave_writedata);
        4'd4:    mode_d = slave_writedata[0];
        4'd5:    fill_d = slave_writedata;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          wsrc_d  = src_q;
          wdst_d  = dst_q;
          rem_d   = len_q;
          wmode_d = mode_q;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          if (len_q == '0)  state_d = FINISH;
          else if (mode_q)  state_d = WR_REQ;
          else              state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        master_read    = 1'b1;
        master_address = wsrc_q;
        if (!master_waitrequest) state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (master_readdatavalid) begin
          data_d  = master_readdata;
          state_d = WR_REQ;
        end
      end

      WR_REQ: begin
        master_write     = 1'b1;
        master_address   = wdst_q;
        master_writedata = wmode_q ? fill_q : data_q;
        if (!master_waitrequest) begin
          wsrc_d = wsrc_q + STEP;
          wdst_d = wdst_q + STEP;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = FINISH;
          else if (wmode_q)       state_d = WR_REQ;
          else                    state_d = RD_REQ;
        end
      end

      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      wsrc_q  <= '0;
      wdst_q  <= '0;
      rem_q   <= '0;
      wmode_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      wsrc_q  <= wsrc_d;
      wdst_q  <= wdst_d;
      rem_q   <= rem_d;
      wmode_q <= wmode_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/mem_block_xfer.md
Name: mem_block_xfer

Overview:
- Parametrised successor to the single-word CPU-to-SDRAM writer: an Avalon-MM memory block-transfer engine.
- The CPU programs source, destination, length and mode through a slave CSR window. A master port then moves or fills a block of words in SDRAM.
- Used to copy and clear board-state and move-list buffers without CPU word loops.
- Supports copy and fill modes, a programmable word count, busy/done status, and stall-on-busy CSR semantics.

Parameters:
- DW, 32, data width of slave and master data buses (bits).
- AW, 32, master byte-address width.
- LEN_W, 16, width of the word-count register; max transfer is 2^LEN_W-1 words.
- STRIDE, 4, byte increment applied to the addresses per word (DW/8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- slave_waitrequest  out  1  stalls the current CSR access.
- slave_address  in  4  CSR word index.
- slave_read  in  1  CSR read strobe.
- slave_readdata  out  DW  CSR read data, valid in the cycle the read is accepted.
- slave_write  in  1  CSR write strobe.
- slave_writedata  in  DW  CSR write data.
- master_waitrequest  in  1  SDRAM stall.
- master_address  out  AW  byte address.
- master_read  out  1  read request.
- master_readdata  in  DW  read data.
- master_readdatavalid  in  1  read data valid.
- master_write  out  1  write request.
- master_writedata  out  DW  write data.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- CSR map (word index):
  - 0 CTRL/STATUS. Write with bit0=1 starts a transfer. Read returns {0, done, busy} in bits [1:0].
  - 1 SRC byte address.
  - 2 DST byte address.
  - 3 LEN in words (LEN_W bits; upper bits ignored).
  - 4 MODE: bit0 0=copy, 1=fill.
  - 5 FILL value.
  - 6-15: reads return 0, writes ignored.
- Registers 1-5 read back their stored values.
- CSR timing: slave_readdata is combinational from the registers, zero wait.
- Stall rule: slave_waitrequest=1 for any write, or any read other than address 0, while busy. It drops in the cycle busy falls, and the stalled access then completes. Status reads (address 0) never stall.
- Start rule: a start write latches SRC/DST/LEN/MODE into working counters, sets busy=1 and clears done. Start while busy is held off by waitrequest, not dropped.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
  - IDLE: on start, LEN==0 goes to FINISH; else copy goes to RD_REQ, fill goes to WR_REQ.
  - RD_REQ: master_read=1, master_address=src. Hold until master_waitrequest=0, then go to RD_WAIT.
  - RD_WAIT: wait for master_readdatavalid; capture readdata into a data register, then go to WR_REQ. One outstanding read only.
  - WR_REQ: master_write=1, master_address=dst, writedata = data register (copy) or FILL (fill). Hold until master_waitrequest=0. Then src+=STRIDE, dst+=STRIDE, remaining-=1. Go to FINISH if remaining hits 0, else RD_REQ (copy) or WR_REQ (fill).
  - FINISH: busy=0, done=1 for one cycle, then go to IDLE. done stays set until the next start or reset.
- Master outputs stay stable while waitrequest=1. read and write are never both high.
- Addresses wrap modulo 2^AW; no error flagged.
- Unaccepted-start case: CSR writes to regs 1-5 while idle do not disturb done. Reg writes in the same cycle as a start write are impossible: single-port slave.
- Reset values: slave_waitrequest=0, slave_readdata=0, master_read=0, master_write=0, master_address=0, master_writedata=0. All CSRs=0; busy=0, done=0; FSM in IDLE.
- Reset mid-transfer: aborts immediately, outputs return to reset values next cycle. A late readdatavalid in IDLE is ignored.
- Throughput:
  - Copy: 1 word per (read accept + read latency + write accept) cycles.
  - Fill: 1 word per cycle when master_waitrequest=0.

Test Plan:
- Fill: FILL=32'hDEADBEEF, DST=0x100, LEN=4, MODE=1, start → 4 writes to 0x100, 0x104, 0x108, 0x10C with DEADBEEF on consecutive cycles, no reads; status reads 2'b10 after completion.
- Copy: model preloaded with 0x200..0x20C = 1,2,3,4; SRC=0x200, DST=0x300, LEN=4, MODE=0 → alternating read/write; 0x300..0x30C = 1,2,3,4; done=1.
- Backpressure: random master_waitrequest (50%) and read latency of 1-5 cycles during an 8-word copy → address and data stable while stalled, correct final memory, each beat issued exactly once.
- LEN=0 start → no master_read/master_write, done=1 two cycles after the start write.
- CSR stall: write SRC while busy → slave_waitrequest high until the transfer ends, then the write lands. Status reads during busy return 2'b01 with no stall.
- Reset mid-copy after 2 of 6 words: rst_n low for 1 cycle → master strobes 0 next cycle, status 2'b00; a new 2-word fill then completes normally.
